irrigation_timer_ctrl: RTL
==========================

Name: irrigation_timer_ctrl

Overview:
Multi-zone irrigation sequencer, successor to the single-output two-preset controller.
- A start pulse selects short or long duration; each zone enabled in a latched mask is watered in turn, lowest index first.
- Seconds-resolution countdown comes from an internal prescaler on clk_50mhz.
- Drives one valve per zone and a 7-segment status digit (HEX1).

Parameters:
- CLK_HZ, 50000000: input clock frequency.
- TICK_HZ, 1: countdown tick rate. DIV = CLK_HZ/TICK_HZ must be an integer ≥ 2.
- SHORT_T, 1800: ticks per zone for a short run.
- LONG_T, 3600: ticks per zone for a long run.
- N_ZONES, 4: number of valves, range 1..9.
- CNT_W, 12: countdown width. Must satisfy 2^CNT_W > LONG_T.

Ports:
- clk_50mhz, in, 1: single clock.
- rst_50mhz, in, 1: reset, asynchronous, active-low.
- start_short, in, 1: async level (switch). Its rising edge requests a short run.
- start_long, in, 1: async level. Its rising edge requests a long run.
- stop, in, 1: async level. While high, forces IDLE.
- zone_en, in, N_ZONES: zone enable mask, sampled only at start.
- valve, out, N_ZONES: one-hot or all-zero valve drive.
- busy, out, 1: high in RUN and GAP.
- zone_idx, out, 4: index of the current zone; 0 in IDLE.
- remaining, out, CNT_W: ticks left in the current zone; 0 in IDLE.
- HEX1, out, [0:6]: segments a..g, active-low.

Behaviour:
- Reset: all outputs 0 except HEX1 = IDLE glyph "-" (7'b1111110). State = IDLE, prescaler = 0, mask = 0.
- Input conditioning:
  - start_short, start_long and stop each pass through a 2-flop synchronizer.
  - The starts then pass an edge detector: sync2 & ~prev.
- States: IDLE, RUN, GAP.
- IDLE:
  - Start edge with exactly one of short/long: latch mask = zone_en and dur = SHORT_T/LONG_T.
  - Load the lowest set bit of the mask as zone_idx, remaining = dur, prescaler = 0, then go to RUN.
  - Both start edges in the same cycle: ignored.
  - zone_en == 0: ignored, stay IDLE.
- RUN:
  - valve[zone_idx] = 1.
  - Prescaler counts 0..DIV-1; tick fires on DIV-1 and wraps to 0.
  - On tick, remaining decrements.
  - Tick with remaining == 1: clear mask[zone_idx] and go to GAP.
- GAP (exactly 1 cycle, all valves 0):
  - If mask != 0: next lowest set index, remaining = dur, prescaler = 0, go to RUN.
  - Else go to IDLE.
- stop (synchronized) high in any state:
  - Next edge forces IDLE: valves 0, mask cleared.
  - Overrides a simultaneous start edge and tick.
  - A start edge is not honoured while stop is high.
- Start edges during RUN/GAP are ignored; no restart or extension.
- Latency: counting the edge that first samples a raw start high as edge 0, state = RUN and valve high after edge 2.
- Zone timing: each zone's valve is high for exactly dur·DIV cycles, followed by one all-off cycle.
- HEX1:
  - IDLE shows "-".
  - RUN/GAP shows digit zone_idx+1.
  - Uses standard active-low codes, e.g. "1" = 7'b1001111.
- Async reset mid-run: immediately drops all valves.

Optional Feature:
- Macro: IRRIGATION_RAIN_SENSOR_EN.
- Enabled:
  - Adds input port rain (1 bit, async, 2-flop synchronized) and state PAUSE.
  - In RUN with rain high: go to PAUSE. Valves 0, prescaler and remaining frozen, HEX1 = "P" (7'b0011000).
  - rain low: return to RUN and resume the same zone and count.
  - stop still forces IDLE.
  - Start edge in IDLE with rain high: ignored.
- Disabled: no rain port, no PAUSE state.

Decomposition:
- Package irrigation_pkg holds:
  - State enum.
  - Segment constants SEG_DASH, SEG_P and a digit table for 1..9.
  - Function lowest_set(mask) returning an index.
- One sub-module, tick_prescaler (params DIV; ports clk_50mhz, rst_50mhz, clr, en → tick).
  - Counter width is $clog2(DIV).
  - en is low in PAUSE.

Test Plan:
(Sim params: CLK_HZ=10, TICK_HZ=1, SHORT_T=3, LONG_T=5, N_ZONES=4.)
1. zone_en=4'b1011, start_short pulse → valve 0001 for 30 cycles, 1 gap, 0010 for 30, 1 gap, 1000 for 30, then IDLE. HEX1 shows 1, 2, 4, then "-".
2. zone_en=4'b0100, start_long → valve 0100 for exactly 50 cycles. remaining steps 5,4,3,2,1. busy low after the GAP cycle.
3. start_short and start_long rising in the same cycle, or zone_en=0 → no state change, valve stays 0.
4. stop asserted mid zone 2 in the same cycle as a tick → IDLE 3 edges after the raw stop. Valves 0, mask cleared, a later start begins at the lowest enabled zone.
5. Second start edge during RUN, plus zone_en changed mid-run → ignored. Sequence follows the latched mask.
6. (RAIN_EN) rain high for 17 cycles at remaining=2 → PAUSE, valve 0, HEX1 "P". Resumes with remaining=2 and the same prescaler value; total valve-high time is still 30 cycles.

Source files
------------

// File: rtl/irrigation_pkg.sv
// Shared states, 7-segment codes and helpers for the irrigation sequencer.
// IRRIGATION_RAIN_SENSOR_EN adds the PAUSE state.
package irrigation_pkg;

  localparam int MAX_ZONES = 9;

`ifdef IRRIGATION_RAIN_SENSOR_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP,
    ST_PAUSE
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP
  } state_e;
`endif

  // Segment order a..g, active-low
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [6:0] SEG_P    = 7'b0011000;

  localparam logic [6:0] SEG_DIGIT [1:9] = '{
    7'b1001111,
    7'b0010010,
    7'b0000110,
    7'b1001100,
    7'b0100100,
    7'b0100000,
    7'b0001111,
    7'b0000000,
    7'b0000100
  };

  function automatic logic [6:0] seg_digit(
    input logic [3:0] d
  );
    logic [6:0] s;
    s = SEG_DASH;
    if (d >= 4'd1 && d <= 4'd9)
      s = SEG_DIGIT[d];
    return s;
  endfunction

  function automatic logic [3:0] lowest_set(
    input logic [MAX_ZONES-1:0] mask
  );
    logic [3:0] idx;
    idx = '0;
    for (int i = MAX_ZONES - 1; i >= 0; i--)
      if (mask[i]) idx = 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/irrigation_timer_ctrl_tick_prescaler.sv
// Divides the system clock down to the countdown tick.
// Holds its count while en is low; clr returns it to zero.
module tick_prescaler #(
  parameter int DIV = 2
) (
  input  logic clk_50mhz,
  input  logic rst_50mhz,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk_50mhz or negedge rst_50mhz) begin
    if (!rst_50mhz) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

endmodule

// File: rtl/irrigation_timer_ctrl.sv
// Multi-zone irrigation sequencer: waters each latched zone in turn.
// Define IRRIGATION_RAIN_SENSOR_EN for the rain input and PAUSE state.
module irrigation_timer_ctrl
  import irrigation_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1,
  parameter int SHORT_T = 1800,
  parameter int LONG_T  = 3600,
  parameter int N_ZONES = 4,
  parameter int CNT_W   = 12
) (
  input  logic               clk_50mhz,
  input  logic               rst_50mhz,
`ifdef IRRIGATION_RAIN_SENSOR_EN
  input  logic               rain,
`endif
  input  logic               start_short,
  input  logic               start_long,
  input  logic               stop,
  input  logic [N_ZONES-1:0] zone_en,
  output logic [N_ZONES-1:0] valve,
  output logic               busy,
  output logic [3:0]         zone_idx,
  output logic [CNT_W-1:0]   remaining,
  output logic [0:6]         HEX1
);

  localparam int DIV = CLK_HZ / TICK_HZ;
`ifdef IRRIGATION_RAIN_SENSOR_EN
  localparam int NS = 4;
`else
  localparam int NS = 3;
`endif

  logic [NS-1:0] raw, s1_q, s2_q;
  logic [1:0]    prev_q;

`ifdef IRRIGATION_RAIN_SENSOR_EN
  logic rain_s;
  assign raw    = {rain, stop, start_long, start_short};
  assign rain_s = s2_q[3];
`else
  assign raw = {stop, start_long, start_short};
`endif

  logic ss_e, sl_e, stop_s, go, tick;
  assign ss_e   = s2_q[0] & ~prev_q[0];
  assign sl_e   = s2_q[1] & ~prev_q[1];
  assign stop_s = s2_q[2];

  state_e             state_q, state_d;
  logic [N_ZONES-1:0] mask_q, mask_d, zone_oh;
  logic [CNT_W-1:0]   dur_q, dur_d, rem_q, rem_d, new_dur;
  logic [3:0]         zone_q, zone_d;

  assign zone_oh = N_ZONES'(1) << zone_q;
  assign new_dur = ss_e ? CNT_W'(SHORT_T) : CNT_W'(LONG_T);
`ifdef IRRIGATION_RAIN_SENSOR_EN
  assign go = (ss_e ^ sl_e) && |zone_en && !rain_s;
`else
  assign go = (ss_e ^ sl_e) && |zone_en;
`endif

  tick_prescaler #(.DIV(DIV)) u_presc (
    .clk_50mhz (clk_50mhz),
    .rst_50mhz (rst_50mhz),
    .clr       (state_q == ST_IDLE || state_q == ST_GAP),
    .en        (state_q == ST_RUN),
    .tick      (tick)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    dur_d   = dur_q;
    zone_d  = zone_q;
    rem_d   = rem_q;
    if (stop_s) begin
      state_d = ST_IDLE;
      mask_d  = '0;
      zone_d  = '0;
      rem_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            mask_d  = zone_en;
            dur_d   = new_dur;
            rem_d   = new_dur;
            zone_d  = lowest_set(MAX_ZONES'(zone_en));
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (tick) begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              mask_d  = mask_q & ~zone_oh;
              state_d = ST_GAP;
            end
          end
`ifdef IRRIGATION_RAIN_SENSOR_EN
          if (rain_s && state_d == ST_RUN)
            state_d = ST_PAUSE;
`endif
        end
        ST_GAP: begin
          if (|mask_q) begin
            zone_d  = lowest_set(MAX_ZONES'(mask_q));
            rem_d   = dur_q;
            state_d = ST_RUN;
          end else begin
            zone_d  = '0;
            state_d = ST_IDLE;
          end
        end
`ifdef IRRIGATION_RAIN_SENSOR_EN
        ST_PAUSE: begin
          if (!rain_s) state_d = ST_RUN;
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_50mhz) begin
    if (!rst_50mhz) begin
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
      state_q <= ST_IDLE;
      mask_q  <= '0;
      dur_q   <= '0;
      zone_q  <= '0;
      rem_q   <= '0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      prev_q  <= s2_q[1:0];
      state_q <= state_d;
      mask_q  <= mask_d;
      dur_q   <= dur_d;
      zone_q  <= zone_d;
      rem_q   <= rem_d;
    end
  end

  assign valve     = (state_q == ST_RUN) ? zone_oh : '0;
  assign busy      = (state_q != ST_IDLE);
  assign zone_idx  = zone_q;
  assign remaining = rem_q;

  always_comb begin
    HEX1 = SEG_DASH;
    case (state_q)
      ST_IDLE:  HEX1 = SEG_DASH;
`ifdef IRRIGATION_RAIN_SENSOR_EN
      ST_PAUSE: HEX1 = SEG_P;
`endif
      default:  HEX1 = seg_digit(zone_q + 4'd1);
    endcase
  end

endmodule
